// File: rtl/exibe_resultado_if.sv
`default_nettype none
// ============================================================================
// Module  : exibe_resultado_if
// Purpose : Start/result bus between the calculator core and the display stage.
// Revision: 1.0 - initial release
// ============================================================================
interface exibe_resultado_if #(
    parameter int LARGURA = 14
);
    logic               start;
    logic [LARGURA-1:0] valor;
    logic               negativo;
    logic               busy;
    logic               done;
    logic [0:6]         milR;
    logic [0:6]         cenR;
    logic [0:6]         decR;
    logic [0:6]         uniR;
    logic               sinal;

    modport master (
        output start, valor, negativo,
        input  busy, done, milR, cenR, decR, uniR, sinal
    );

    modport slave (
        input  start, valor, negativo,
        output busy, done, milR, cenR, decR, uniR, sinal
    );
endinterface
`default_nettype wire

// File: rtl/exibe_resultado.sv
`default_nettype none
// ============================================================================
// Module  : exibe_resultado
// Purpose : Sequential double-dabble BCD conversion driving four 7-segment
//           result digits plus an active-low minus indicator.
// Revision: 1.0 - initial release
// ============================================================================
module exibe_resultado #(
    parameter int LARGURA     = 14,
    parameter int APAGA_ZEROS = 1,
    parameter int LIMITE      = 9999
) (
    input  wire logic        clock,
    input  wire logic        reset,
    exibe_resultado_if.slave bus
);
    localparam int             c_CW      = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [c_CW-1:0] c_CNT_INI = c_CW'(LARGURA - 1);
    localparam logic [31:0]    c_LIMITE  = LIMITE;
    localparam logic [0:6]     c_BLANK   = 7'b1111111;
    localparam logic [0:6]     c_E       = 7'b0110000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [LARGURA-1:0] r_shift;
    logic [15:0]        r_bcd;
    logic               r_neg;
    logic               r_zero;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;
    logic [0:6]         r_mil, r_cen, r_dec, r_uni;
    logic               r_sinal;

    logic [15:0]        w_adj;
    logic [0:6]         w_mil, w_cen, w_dec, w_uni;
    logic               w_sinal;

    function automatic logic [0:6] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b0000001;
            4'd1:    f_seg = 7'b1001111;
            4'd2:    f_seg = 7'b0010010;
            4'd3:    f_seg = 7'b0000110;
            4'd4:    f_seg = 7'b1001100;
            4'd5:    f_seg = 7'b0100100;
            4'd6:    f_seg = 7'b0100000;
            4'd7:    f_seg = 7'b0001111;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0000100;
            default: f_seg = c_BLANK;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift
    generate
        for (genvar i = 0; i < 4; i++) begin : g_nib
            assign w_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3
                                                               : r_bcd[i*4 +: 4];
        end
    endgenerate

    always_comb begin
        w_mil   = f_seg(r_bcd[15:12]);
        w_cen   = f_seg(r_bcd[11:8]);
        w_dec   = f_seg(r_bcd[7:4]);
        w_uni   = f_seg(r_bcd[3:0]);
        w_sinal = ~(r_neg & ~r_zero & ~r_ovf);
        if (r_ovf) begin
            w_mil = c_E;
            w_cen = c_E;
            w_dec = c_E;
            w_uni = c_E;
        end else if (APAGA_ZEROS != 0) begin
            // Blank everything left of the most significant nonzero digit
            if (r_bcd[15:12] == 4'd0) begin
                w_mil = c_BLANK;
                if (r_bcd[11:8] == 4'd0) begin
                    w_cen = c_BLANK;
                    if (r_bcd[7:4] == 4'd0) begin
                        w_dec = c_BLANK;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mil   <= c_BLANK;
            r_cen   <= c_BLANK;
            r_dec   <= c_BLANK;
            r_uni   <= c_BLANK;
            r_sinal <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift <= bus.valor;
                        r_neg   <= bus.negativo;
                        r_zero  <= (bus.valor == '0);
                        r_ovf   <= (32'(bus.valor) > c_LIMITE);
                        r_bcd   <= '0;
                        r_cnt   <= c_CNT_INI;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd   <= {w_adj[14:0], r_shift[LARGURA-1]};
                    r_shift <= r_shift << 1;
                    if (r_cnt == '0) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LOAD: begin
                    r_mil   <= w_mil;
                    r_cen   <= w_cen;
                    r_dec   <= w_dec;
                    r_uni   <= w_uni;
                    r_sinal <= w_sinal;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.milR  = r_mil;
    assign bus.cenR  = r_cen;
    assign bus.decR  = r_dec;
    assign bus.uniR  = r_uni;
    assign bus.sinal = r_sinal;
endmodule
`default_nettype wire
